// File: rtl/spi_slave_bridge.sv
`timescale 1ns/1ps
// SPI slave front-end: oversamples the SPI pins on the system clock and bridges them to an
// RX FIFO (valid/ready) and a single-entry TX holding register. All CPOL/CPHA modes supported.
module spi_slave_bridge #(
  parameter int unsigned           DATA_WIDTH  = 8,
  parameter int unsigned           FIFO_DEPTH  = 4,
  parameter bit                    CPOL        = 1'b0,
  parameter bit                    CPHA        = 1'b0,
  parameter bit                    MSB_FIRST   = 1'b1,
  parameter int unsigned           SYNC_STAGES = 2,
  parameter logic [DATA_WIDTH-1:0] TX_IDLE     = '1
) (
  input  logic                        clock,
  input  logic                        rst_n,
  input  logic                        spi_cs_n,
  input  logic                        spi_sck,
  input  logic                        spi_si,
  output logic                        spi_so,
  output logic [DATA_WIDTH-1:0]       rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(FIFO_DEPTH):0] rx_count,
  input  logic [DATA_WIDTH-1:0]       tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        overrun,
  output logic                        underrun,
  output logic                        frame_abort
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CntMax = CW'(DATA_WIDTH);
  localparam logic [AW:0] FifoFull = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StLoad, StShift} state_e;

  function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] shift_in(input logic [DATA_WIDTH-1:0] w,
                                                     input logic b);
    return MSB_FIRST ? {w[DATA_WIDTH-2:0], b} : {b, w[DATA_WIDTH-1:1]};
  endfunction

  // Synchronisers and edge detection
  logic [SYNC_STAGES-1:0] cs_sync_q, sck_sync_q, si_sync_q;
  logic                   cs_d_q, sck_d_q;
  logic                   cs_s, sck_s, si_s;
  logic                   cs_fall, lead_edge, trail_edge, sample_edge, drive_edge;

  // cs chain resets to "asserted" so a frame already in progress at reset release is ignored
  // until cs_n has been seen high and then low again.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync_q  <= '0;
      sck_sync_q <= {SYNC_STAGES{CPOL}};
      si_sync_q  <= '0;
      cs_d_q     <= 1'b0;
      sck_d_q    <= CPOL;
    end else begin
      cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
      si_sync_q  <= {si_sync_q[SYNC_STAGES-2:0], spi_si};
      cs_d_q     <= cs_s;
      sck_d_q    <= sck_s;
    end
  end

  assign cs_s        = cs_sync_q[SYNC_STAGES-1];
  assign sck_s       = sck_sync_q[SYNC_STAGES-1];
  assign si_s        = si_sync_q[SYNC_STAGES-1];
  assign cs_fall     = cs_d_q & ~cs_s;
  assign lead_edge   = (sck_s != CPOL) && (sck_d_q == CPOL);
  assign trail_edge  = (sck_s == CPOL) && (sck_d_q != CPOL);
  assign sample_edge = CPHA ? trail_edge : lead_edge;
  assign drive_edge  = CPHA ? lead_edge : trail_edge;

  // Frame FSM and shifters
  state_e                state_q, state_d;
  logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] hold_q, hold_d;
  logic                  hold_full_q, hold_full_d;
  logic                  so_q, so_d;
  logic                  udr_pend_q, udr_pend_d;
  logic                  underrun_q, underrun_d;
  logic                  abort_q, abort_d;
  logic                  overrun_q, overrun_d;
  logic                  push;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    so_d        = so_q;
    udr_pend_d  = udr_pend_q;
    underrun_d  = 1'b0;
    abort_d     = 1'b0;
    push        = 1'b0;

    if (tx_valid && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    if (cs_s) begin
      state_d    = StIdle;
      so_d       = 1'b0;
      bit_cnt_d  = '0;
      udr_pend_d = 1'b0;
      if (state_q == StShift) begin
        push    = (bit_cnt_q == CntMax);
        abort_d = (bit_cnt_q != '0) && (bit_cnt_q != CntMax);
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cs_fall) state_d = StLoad;
        end
        StLoad: begin
          bit_cnt_d = '0;
          if (hold_full_q) begin
            tx_shift_d  = hold_q;
            hold_full_d = 1'b0;
          end else begin
            tx_shift_d = TX_IDLE;
          end
          // Underrun is reported once the word is actually clocked, so the load that follows
          // the last word of a frame does not count.
          udr_pend_d = !hold_full_q;
          if (!CPHA) so_d = first_bit(tx_shift_d);
          state_d = StShift;
        end
        StShift: begin
          if (bit_cnt_q == CntMax) begin
            push    = 1'b1;
            state_d = StLoad;
          end else begin
            if (sample_edge) begin
              rx_shift_d = shift_in(rx_shift_q, si_s);
              bit_cnt_d  = bit_cnt_q + CW'(1);
              if (bit_cnt_q == '0) underrun_d = udr_pend_q;
            end
            if (drive_edge) begin
              // With CPHA=0 the first bit is already out, and the trailing edge of the
              // previous word's last bit arrives while the counter is still zero.
              if (bit_cnt_q == '0) begin
                if (CPHA) so_d = first_bit(tx_shift_q);
              end else begin
                tx_shift_d = advance(tx_shift_q);
                so_d       = first_bit(tx_shift_d);
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // RX FIFO
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           count_q;
  logic                  pop, full, push_ok;

  assign pop       = rx_valid & rx_ready;
  assign full      = (count_q == FifoFull);
  assign push_ok   = push & (~full | pop);
  assign overrun_d = push & full & ~pop;

  always_ff @(posedge clock) begin
    if (push_ok) mem_q[wr_ptr_q] <= rx_shift_q;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      so_q        <= 1'b0;
      udr_pend_q  <= 1'b0;
      underrun_q  <= 1'b0;
      abort_q     <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      so_q        <= so_d;
      udr_pend_q  <= udr_pend_d;
      underrun_q  <= underrun_d;
      abort_q     <= abort_d;
      overrun_q   <= overrun_d;
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count_q <= count_q + (AW + 1)'(1);
        2'b01:   count_q <= count_q - (AW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rx_data     = mem_q[rd_ptr_q];
  assign rx_valid    = (count_q != '0);
  assign rx_count    = count_q;
  assign tx_ready    = ~hold_full_q;
  assign spi_so      = so_q;
  assign overrun     = overrun_q;
  assign underrun    = underrun_q;
  assign frame_abort = abort_q;

endmodule

// File: tb/tb_spi_slave_bridge.sv
`timescale 1ns/1ps
// Bench for spi_slave_bridge: a bit-banged SPI master drives a mode-0/MSB-first instance and a
// mode-3/LSB-first instance; popped RX words are checked against a queue of expected words.
module tb_spi_slave_bridge;

  localparam int H = 6;  // system clocks per SCK half period

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, sel, m_cs, m_sck, m_si, rdy, txv;
  logic [7:0] txd;

  logic       a_so, a_rxv, a_txr, a_ovr, a_udr, a_abt;
  logic [7:0] a_rxd;
  logic [2:0] a_rxc;
  logic       b_so, b_rxv, b_txr, b_ovr, b_udr, b_abt;
  logic [7:0] b_rxd;
  logic [2:0] b_rxc;

  spi_slave_bridge u_mode0 (
    .clock(clk), .rst_n(rst_n),
    .spi_cs_n(sel ? 1'b1 : m_cs), .spi_sck(sel ? 1'b0 : m_sck), .spi_si(m_si), .spi_so(a_so),
    .rx_data(a_rxd), .rx_valid(a_rxv), .rx_ready(rdy & ~sel), .rx_count(a_rxc),
    .tx_data(txd), .tx_valid(txv & ~sel), .tx_ready(a_txr),
    .overrun(a_ovr), .underrun(a_udr), .frame_abort(a_abt)
  );

  spi_slave_bridge #(.CPOL(1'b1), .CPHA(1'b1), .MSB_FIRST(1'b0)) u_mode3 (
    .clock(clk), .rst_n(rst_n),
    .spi_cs_n(sel ? m_cs : 1'b1), .spi_sck(sel ? m_sck : 1'b1), .spi_si(m_si), .spi_so(b_so),
    .rx_data(b_rxd), .rx_valid(b_rxv), .rx_ready(rdy & sel), .rx_count(b_rxc),
    .tx_data(txd), .tx_valid(txv & sel), .tx_ready(b_txr),
    .overrun(b_ovr), .underrun(b_udr), .frame_abort(b_abt)
  );

  wire       so  = sel ? b_so  : a_so;
  wire       rxv = sel ? b_rxv : a_rxv;
  wire [7:0] rxd = sel ? b_rxd : a_rxd;
  wire [2:0] rxc = sel ? b_rxc : a_rxc;
  wire       txr = sel ? b_txr : a_txr;
  wire       ovr = sel ? b_ovr : a_ovr;
  wire       udr = sel ? b_udr : a_udr;
  wire       abt = sel ? b_abt : a_abt;

  int         checks = 0, errors = 0;
  int         ovr_n = 0, udr_n = 0, abt_n = 0;
  logic [7:0] exp_q[$];
  logic [7:0] r, r0, r1, r2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pulse counters and RX scoreboard (a pop happens at the next rising edge)
  always @(negedge clk) begin
    if (rst_n) begin
      if (ovr) ovr_n++;
      if (udr) udr_n++;
      if (abt) abt_n++;
      if (rxv && rdy) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rx_pop: got %0h expected no word", rxd);
        end else begin
          check("rx_data", {24'h0, rxd}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic xfer(input int nbits, input logic [7:0] mosi, output logic [7:0] miso);
    logic cpol, cpha, msb;
    int   idx;
    cpol = sel;
    cpha = sel;
    msb  = ~sel;
    miso = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = msb ? 7 - i : i;
      if (!cpha) begin
        m_si = mosi[idx];
        tick(H);
        m_sck = ~cpol;
        miso[idx] = so;
        tick(H);
        m_sck = cpol;
      end else begin
        m_sck = ~cpol;
        m_si = mosi[idx];
        tick(H);
        m_sck = cpol;
        miso[idx] = so;
        tick(H);
      end
    end
  endtask

  task automatic cs_low();
    m_cs = 1'b0;
    tick(H);
  endtask

  task automatic cs_high();
    tick(H);
    m_cs = 1'b1;
    tick(12);
  endtask

  task automatic offer(input logic [7:0] w);
    int n;
    n = 0;
    while (!txr && n < 300) begin
      tick(1);
      n++;
    end
    check("tx_ready_wait", {31'h0, txr}, 32'h1);
    txv = 1'b1;
    txd = w;
    tick(1);
    txv = 1'b0;
  endtask

  task automatic drain();
    rdy = 1'b1;
    for (int i = 0; i < 50 && rxv; i++) tick(1);
    rdy = 1'b0;
    check("drain_empty", {31'h0, rxv}, 32'h0);
  endtask

  task automatic clear_pulses();
    ovr_n = 0;
    udr_n = 0;
    abt_n = 0;
  endtask

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    sel = 1'b0; m_cs = 1'b1; m_sck = 1'b0; m_si = 1'b0;
    rdy = 1'b0; txv = 1'b0; txd = '0; rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(5);

    // Reset state
    check("rst_spi_so", {31'h0, so}, 32'h0);
    check("rst_rx_valid", {31'h0, rxv}, 32'h0);
    check("rst_rx_count", {29'h0, rxc}, 32'h0);
    check("rst_tx_ready", {31'h0, txr}, 32'h1);
    check("rst_pulses", ovr_n + udr_n + abt_n, 32'h0);

    // Mode 0: 0xA5 in, 0x3C out
    offer(8'h3C);
    check("tx_ready_low", {31'h0, txr}, 32'h0);
    cs_low();
    xfer(8, 8'hA5, r);
    exp_q.push_back(8'hA5);
    cs_high();
    check("m0_rx_valid", {31'h0, rxv}, 32'h1);
    check("m0_rx_count", {29'h0, rxc}, 32'h1);
    check("m0_miso", {24'h0, r}, 32'h3C);
    check("m0_tx_ready", {31'h0, txr}, 32'h1);
    check("m0_underrun", udr_n, 32'h0);
    drain();
    check("m0_count_after", {29'h0, rxc}, 32'h0);

    // Mode 3, LSB first: 3-word frame with streaming TX
    m_sck = 1'b1;
    sel   = 1'b1;
    tick(10);
    clear_pulses();
    offer(8'h12);
    fork
      begin
        offer(8'h34);
        offer(8'h56);
      end
      begin
        cs_low();
        xfer(8, 8'h01, r0);
        xfer(8, 8'h80, r1);
        xfer(8, 8'hFF, r2);
        cs_high();
      end
    join
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    exp_q.push_back(8'hFF);
    check("m3_miso0", {24'h0, r0}, 32'h12);
    check("m3_miso1", {24'h0, r1}, 32'h34);
    check("m3_miso2", {24'h0, r2}, 32'h56);
    check("m3_rx_count", {29'h0, rxc}, 32'h3);
    check("m3_pulses", ovr_n + udr_n + abt_n, 32'h0);
    drain();
    sel   = 1'b0;
    m_sck = 1'b0;
    tick(10);

    // Overrun with rx_ready low; no TX data so every word is an underrun of 0xFF
    clear_pulses();
    cs_low();
    for (int k = 0; k < 5; k++) begin
      xfer(8, 8'h10 + 8'(k), r);
      check("udr_miso", {24'h0, r}, 32'hFF);
      if (k < 4) exp_q.push_back(8'h10 + 8'(k));
    end
    cs_high();
    check("ovr_rx_count", {29'h0, rxc}, 32'h4);
    check("ovr_pulses", ovr_n, 32'h1);
    check("udr_pulses", udr_n, 32'h5);
    drain();
    check("ovr_count_after", {29'h0, rxc}, 32'h0);

    // Partial word abort, then a clean frame
    clear_pulses();
    cs_low();
    xfer(3, 8'hFF, r);
    cs_high();
    check("abort_pulses", abt_n, 32'h1);
    check("abort_rx_count", {29'h0, rxc}, 32'h0);
    cs_low();
    xfer(8, 8'h5A, r);
    exp_q.push_back(8'h5A);
    cs_high();
    check("post_abort_count", {29'h0, rxc}, 32'h1);
    check("post_abort_pulses", abt_n, 32'h1);
    drain();

    // Reset mid-word with two words buffered
    cs_low();
    xfer(8, 8'h11, r);
    xfer(8, 8'h22, r);
    cs_high();
    check("pre_rst_count", {29'h0, rxc}, 32'h2);
    cs_low();
    xfer(4, 8'h99, r);
    check("pre_rst_so", {31'h0, so}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_rx_valid", {31'h0, rxv}, 32'h0);
    check("rst_mid_rx_count", {29'h0, rxc}, 32'h0);
    check("rst_mid_so", {31'h0, so}, 32'h0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    xfer(4, 8'h99, r);
    cs_high();
    check("post_rst_ignored", {29'h0, rxc}, 32'h0);
    cs_low();
    xfer(8, 8'hC3, r);
    exp_q.push_back(8'hC3);
    cs_high();
    check("post_rst_count", {29'h0, rxc}, 32'h1);
    drain();

    check("scoreboard_empty", exp_q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
